draw_pipes: RTL and testbench
=============================

// Module: draw_pipes
// PURPOSE
//  Parametrised successor to the fixed-rectangle game drawer. Draws N_PIPES scrolling pipe pairs,
//  each a column with a vertical gap. Pipes move left once per frame and wrap with a new
//  pseudo-random gap height. Pulses score_pulse when a pipe passes BIRD_X. Sits between the VGA
//  timing source (vga_if) and the layer mixer. Outputs rgb/valid as an overlay layer.
// PARAMETERS
//  N_PIPES       3        number of pipe pairs (1..8)
//  SCREEN_W      800      visible width, px
//  SCREEN_H      600      visible height, px; frame tick at vcount==SCREEN_H, hcount==0
//  PIPE_W        80       pipe width, px
//  PIPE_SPACING  300      distance between left edges of consecutive pipes, px
//  SPEED         2        px moved per frame tick (1..PIPE_SPACING-1)
//  GAP_H         160      gap height, px
//  GAP_MIN       100      minimum gap top y
//  GAP_MASK      255      gap_y = GAP_MIN + (lfsr & GAP_MASK); GAP_MIN+GAP_MASK+GAP_H <= SCREEN_H
//  BIRD_X        200      x column used for scoring
//  PIPE_COLOR    12'h0F0  pipe body colour
//  LFSR_SEED     8'hA5    non-zero LFSR reset value
// PORTS
//  clk          in   1    pixel clock
//  rst          in   1    synchronous active-high reset
//  vin          in   vga_if.in   hcount/vcount timing (11 bit each)
//  run          in   1    1 = pipes scroll on frame tick; 0 = positions frozen
//  rgb          out  12   pixel colour, valid when valid==1
//  valid        out  1    1 = pixel belongs to a pipe
//  score_pulse  out  1    one-clk pulse when a pipe's right edge crosses BIRD_X
// BEHAVIOUR
//  - Reset: rgb=0, valid=0, score_pulse=0. x[i]=SCREEN_W+i*PIPE_SPACING. gap_y[i]=GAP_MIN+64*i.
//    lfsr=LFSR_SEED. Reset mid-frame takes effect on the next edge; no partial update survives.
//  - x[i] is 12-bit signed (left edge, may be negative). gap_y[i] is 10-bit unsigned.
//  - LFSR: 8-bit Galois, taps x^8+x^6+x^5+x^4+1. Advances every clk.
//  - Frame tick: single cycle with vin.vcount==SCREEN_H && vin.hcount==0. At most once per frame.
//  - On tick with run=1, for each i: xn=x[i]-SPEED.
//      If xn <= -PIPE_W: x[i]<=xn+N_PIPES*PIPE_SPACING, gap_y[i]<=GAP_MIN+(lfsr&GAP_MASK).
//      Otherwise x[i]<=xn.
//  - Tick with run=0, or no tick: x/gap_y hold.
//  - score_pulse=1 for the cycle after a tick where, for any i, old x[i]+PIPE_W > BIRD_X and
//    xn+PIPE_W <= BIRD_X. Simultaneous crossings (only possible with overlapping config) still
//    give one pulse.
//  - Draw, latency 1 clk (registered):
//      hit_i = (hcount >= x[i]) && (hcount < x[i]+PIPE_W) && (vcount < gap_y[i] || vcount >= gap_y[i]+GAP_H)
//      Compare signed, with hcount zero-extended. valid<=|hit. rgb<=valid ? PIPE_COLOR : 0.
//      Lowest index wins on overlap.
//  - Pixels at hcount>=SCREEN_W or vcount>=SCREEN_H: valid<=0, rgb<=0.
//  - Draw uses x/gap_y values registered before the current cycle. A tick-cycle update is
//    visible from the following pixel; it falls in blanking, so there is no tearing.
// CONFIGURATION
//  PIPE_CAP_EN defined:
//    - Each pipe draws a lip CAP_H=16 px tall, directly above gap_y[i] and directly below gap_y[i]+GAP_H.
//    - Lip spans x[i]-4 .. x[i]+PIPE_W+3. Lip colour 12'h070; lip overrides body.
//    - Lip pixels set valid=1.
//  PIPE_CAP_EN undefined:
//    - No lip logic. Body only, exactly as above.
//  Neither setting changes scoring or motion.
// TESTING
//  1 Reset, run=1, one frame tick -> x0=798, x1=1098, x2=1398; rgb=0, valid=0 throughout reset.
//  2 100 ticks (x0=600, gap_y0=100); hcount=650 at vcount=50 / 150 / 260 -> valid 1 / 0 / 1 one
//    clk later; rgb=12'h0F0 when valid.
//  3 440 ticks -> x0 reaches -80 and wraps to 820. gap_y0 in [100,355] and equals
//    GAP_MIN+(lfsr&255) sampled at the tick.
//  4 Scoring: the 340th tick (x0 122->120, right edge 202->200) -> score_pulse high exactly
//    1 clk; no pulse on ticks 339 and 341.
//  5 run=0 for 50 frames -> x/gap_y unchanged, drawing continues. run=1 -> decrement resumes
//    on the next tick.
//  6 Assert rst mid-line (hcount=400, vcount=300) after 200 ticks -> next clk valid=0, x0=800.
//    The frame after release draws no pipe at hcount<800.

Source files
------------

// File: rtl/draw_pipes_if.sv
// vga_if: VGA raster position shared between the timing generator and the
// layer drawers.
//   hcount [10:0]  current pixel column
//   vcount [10:0]  current line
// Modports:
//   out  driven by the timing generator
//   in   read by drawers such as draw_pipes
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;

  modport out (output hcount, output vcount);
  modport in  (input  hcount, input  vcount);
endinterface

// File: rtl/draw_pipes.sv
// draw_pipes: overlay layer that draws N_PIPES scrolling pipe pairs. Each
// pipe is a PIPE_W wide column with a GAP_H tall opening. Pipes move left
// SPEED px per frame tick. When a pipe leaves the screen it wraps to the
// right with a new pseudo-random gap height. score_pulse fires once when a
// pipe's right edge passes BIRD_X.
//
// Ports:
//   clk          pixel clock
//   rst          synchronous, active-high reset
//   vin          raster position (vga_if.in)
//   run          1 = pipes scroll on frame ticks, 0 = positions frozen
//   rgb [11:0]   pixel colour, registered, meaningful when valid = 1
//   valid        pixel belongs to a pipe (registered, 1 clk latency)
//   score_pulse  one-clock pulse in the cycle after a scoring tick
//
// Build option:
//   PIPE_CAP_EN  when defined, each pipe also draws a 16 px lip directly above
//                and directly below its gap. The lip is 4 px wider than the
//                body on each side and uses colour 12'h070.
module draw_pipes #(
  parameter int          N_PIPES      = 3,
  parameter int          SCREEN_W     = 800,
  parameter int          SCREEN_H     = 600,
  parameter int          PIPE_W       = 80,
  parameter int          PIPE_SPACING = 300,
  parameter int          SPEED        = 2,
  parameter int          GAP_H        = 160,
  parameter int          GAP_MIN      = 100,
  parameter int          GAP_MASK     = 255,
  parameter int          BIRD_X       = 200,
  parameter logic [11:0] PIPE_COLOR   = 12'h0F0,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  vga_if.in           vin,
  input  logic        run,
  output logic [11:0] rgb,
  output logic        valid,
  output logic        score_pulse
);

  // All x arithmetic is 13-bit signed. That is wide enough for a left edge
  // in -PIPE_W..N_PIPES*PIPE_SPACING plus PIPE_W, with no overflow.
  localparam logic signed [12:0] PW_S     = 13'(PIPE_W);
  localparam logic signed [12:0] SPD_S    = 13'(SPEED);
  localparam logic signed [12:0] WRAP_S   = 13'(N_PIPES * PIPE_SPACING);
  localparam logic signed [12:0] BX_S     = 13'(BIRD_X);
  localparam logic [11:0]        GAP_H_V  = 12'(GAP_H);
  localparam logic [9:0]         GAP_MIN_V  = 10'(GAP_MIN);
  localparam logic [7:0]         GAP_MASK_V = 8'(GAP_MASK);
`ifdef PIPE_CAP_EN
  localparam logic [11:0]        CAP_H_V   = 12'd16;
  localparam logic signed [12:0] LIP_OUT_S = 13'sd4;
  localparam logic [11:0]        LIP_COLOR = 12'h070;
`endif

  logic signed [11:0] x_q     [N_PIPES];
  logic signed [11:0] x_d     [N_PIPES];
  logic [9:0]         gap_y_q [N_PIPES];
  logic [9:0]         gap_y_d [N_PIPES];
  logic [7:0]         lfsr_q, lfsr_d;
  logic [11:0]        rgb_q, rgb_d;
  logic               valid_q, valid_d;
  logic               score_pulse_q, score_pulse_d;

  logic               tick;
  logic signed [12:0] hc_s;
  logic [11:0]        vc_u;

  // The frame tick is the first pixel of the first blanking line.
  assign tick = (vin.vcount == 11'(SCREEN_H)) && (vin.hcount == 11'd0);
  assign hc_s = $signed({2'b00, vin.hcount});
  assign vc_u = {1'b0, vin.vcount};

  // Motion, wrap and scoring.
  always_comb begin : motion
    logic signed [12:0] x_old;
    logic signed [12:0] x_new;
    // NOTE: every combinational output gets a default before any branch, so
    // no path leaves a variable unassigned and no latch is inferred.
    x_d           = x_q;
    gap_y_d       = gap_y_q;
    score_pulse_d = 1'b0;
    x_old         = '0;
    x_new         = '0;
    // Galois LFSR, x^8+x^6+x^5+x^4+1 in right-shift form (toggle mask 0xB8).
    lfsr_d = {1'b0, lfsr_q[7:1]} ^ (lfsr_q[0] ? 8'hB8 : 8'h00);

    if (tick && run) begin
      for (int i = 0; i < N_PIPES; i++) begin
        x_old = 13'(x_q[i]);
        x_new = x_old - SPD_S;
        if (x_new <= -PW_S) begin
          x_d[i]     = 12'(x_new + WRAP_S);
          gap_y_d[i] = GAP_MIN_V + {2'b00, lfsr_q & GAP_MASK_V};
        end else begin
          x_d[i] = 12'(x_new);
        end
        // Several pipes crossing on the same tick are OR-ed into one pulse.
        if ((x_old + PW_S > BX_S) && (x_new + PW_S <= BX_S)) begin
          score_pulse_d = 1'b1;
        end
      end
    end
  end

  // Pixel classification against the registered pipe state. The loop runs
  // from the highest index down, so the lowest-index pipe is written last
  // and wins where pipes overlap.
  always_comb begin : draw
    logic signed [12:0] xl;
    logic [11:0]        gt;
    logic [11:0]        gb;
    logic               body;
    logic               any_hit;
    logic               in_screen;
    logic [11:0]        pix;
`ifdef PIPE_CAP_EN
    logic               lip;
    lip = 1'b0;
`endif
    xl      = '0;
    gt      = '0;
    gb      = '0;
    body    = 1'b0;
    any_hit = 1'b0;
    pix     = '0;

    for (int i = N_PIPES - 1; i >= 0; i--) begin
      xl   = 13'(x_q[i]);
      gt   = {2'b00, gap_y_q[i]};
      gb   = gt + GAP_H_V;
      body = (hc_s >= xl) && (hc_s < xl + PW_S) && ((vc_u < gt) || (vc_u >= gb));
`ifdef PIPE_CAP_EN
      // GAP_MIN >= CAP_H, so gt - CAP_H_V never underflows.
      lip = (hc_s >= xl - LIP_OUT_S) && (hc_s < xl + PW_S + LIP_OUT_S) &&
            (((vc_u >= gt - CAP_H_V) && (vc_u < gt)) ||
             ((vc_u >= gb) && (vc_u < gb + CAP_H_V)));
      if (lip) begin
        any_hit = 1'b1;
        pix     = LIP_COLOR;
      end else if (body) begin
        any_hit = 1'b1;
        pix     = PIPE_COLOR;
      end
`else
      if (body) begin
        any_hit = 1'b1;
        pix     = PIPE_COLOR;
      end
`endif
    end

    in_screen = (vin.hcount < 11'(SCREEN_W)) && (vin.vcount < 11'(SCREEN_H));
    valid_d   = in_screen && any_hit;
    rgb_d     = valid_d ? pix : 12'h000;
  end

  // NOTE: state is updated with non-blocking assignments. Then every flop
  // samples its _d value from before the edge, whatever the statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the per-pipe arrays are a handful of flops, not a RAM, so they
      // are reset explicitly. The first frame then draws from a known layout.
      for (int i = 0; i < N_PIPES; i++) begin
        x_q[i]     <= 12'(SCREEN_W + i * PIPE_SPACING);
        gap_y_q[i] <= 10'(GAP_MIN + 64 * i);
      end
      lfsr_q        <= LFSR_SEED;
      rgb_q         <= 12'h000;
      valid_q       <= 1'b0;
      score_pulse_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      gap_y_q       <= gap_y_d;
      lfsr_q        <= lfsr_d;
      rgb_q         <= rgb_d;
      valid_q       <= valid_d;
      score_pulse_q <= score_pulse_d;
    end
  end

  assign rgb         = rgb_q;
  assign valid       = valid_q;
  assign score_pulse = score_pulse_q;

endmodule

// File: tb/tb_draw_pipes.sv
// tb_draw_pipes: directed bench for draw_pipes with default parameters and
// the default build (no pipe lips). Inputs are driven on the falling edge and
// outputs are sampled on the next falling edge.
module tb_draw_pipes;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [11:0] rgb;
  logic        valid;
  logic        score_pulse;

  always #5 clk = ~clk;

  vga_if vif ();

  draw_pipes dut (
    .clk         (clk),
    .rst         (rst),
    .vin         (vif),
    .run         (run),
    .rgb         (rgb),
    .valid       (valid),
    .score_pulse (score_pulse)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference state for the pipes, worked out from the behaviour
  // description.
  int          exp_x   [3];
  int          exp_gap [3];
  logic [7:0]  m_lfsr;
  logic [7:0]  tick_lfsr;

  // Reference LFSR. It is reseeded while rst is high and otherwise advances
  // every clock. Its value is captured at each frame tick for the wrap check.
  always @(posedge clk) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {1'b0, m_lfsr[7:1]} ^ (m_lfsr[0] ? 8'hB8 : 8'h00);
    if (!rst && vif.vcount == 11'd600 && vif.hcount == 11'd0) tick_lfsr <= m_lfsr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d required %0d", tag, $signed(obs), $signed(exp));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      exp_x[i]   = 800 + 300 * i;
      exp_gap[i] = 100 + 64 * i;
    end
  endtask

  // One frame tick: tick pixel for one clock, then a blanking pixel. The
  // score pulse must appear exactly in the first sampled cycle.
  task automatic do_tick(input logic r, output logic sp);
    int   xn;
    logic exp_sp;
    run        = r;
    vif.vcount = 11'd600;
    vif.hcount = 11'd0;
    @(negedge clk);
    exp_sp = 1'b0;
    if (r) begin
      for (int i = 0; i < 3; i++) begin
        xn = exp_x[i] - 2;
        if (exp_x[i] + 80 > 200 && xn + 80 <= 200) exp_sp = 1'b1;
        if (xn <= -80) begin
          exp_x[i]   = xn + 900;
          exp_gap[i] = 100 + int'(tick_lfsr);
        end else begin
          exp_x[i] = xn;
        end
      end
    end
    sp = score_pulse;
    check("score_on_tick", 32'(score_pulse), 32'(exp_sp));
    vif.vcount = 11'd601;
    vif.hcount = 11'd0;
    @(negedge clk);
    check("score_after", 32'(score_pulse), 32'd0);
  endtask

  task automatic probe(input int h, input int v, input logic exp_v, input string tag);
    vif.hcount = 11'(h);
    vif.vcount = 11'(v);
    @(negedge clk);
    check({tag, "_valid"}, 32'(valid), 32'(exp_v));
    check({tag, "_rgb"}, 32'(rgb), exp_v ? 32'h0F0 : 32'h000);
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < 3; i++) begin
      check({tag, "_x"}, 32'(dut.x_q[i]), 32'(exp_x[i]));
      check({tag, "_gap"}, 32'(dut.gap_y_q[i]), 32'(exp_gap[i]));
    end
  endtask

  initial begin
    logic sp;
    logic any_v;

    // Reset, with a tick pixel presented: nothing moves, and the outputs stay 0.
    rst        = 1'b1;
    run        = 1'b1;
    vif.hcount = 11'd0;
    vif.vcount = 11'd600;
    repeat (3) begin
      @(negedge clk);
      check("rst_valid", 32'(valid), 32'd0);
      check("rst_rgb", 32'(rgb), 32'd0);
      check("rst_score", 32'(score_pulse), 32'd0);
    end
    check("rst_x0", 32'(dut.x_q[0]), 32'd800);
    vif.vcount = 11'd601;
    rst        = 1'b0;
    model_reset();
    @(negedge clk);

    // 1: first tick.
    do_tick(1'b1, sp);
    check("t1_x0", 32'(dut.x_q[0]), 32'd798);
    check("t1_x1", 32'(dut.x_q[1]), 32'd1098);
    check("t1_x2", 32'(dut.x_q[2]), 32'd1398);

    // 2: 100 ticks, then pixel classification around pipe 0 at x=600, gap 100..259.
    repeat (99) do_tick(1'b1, sp);
    check("t2_x0", 32'(dut.x_q[0]), 32'd600);
    check("t2_gap0", 32'(dut.gap_y_q[0]), 32'd100);
    probe(650, 50,  1'b1, "t2_top");
    probe(650, 150, 1'b0, "t2_gap");
    probe(650, 260, 1'b1, "t2_bottom");
    probe(650, 259, 1'b0, "t2_gap_last");
    probe(650, 99,  1'b1, "t2_top_last");
    probe(599, 50,  1'b0, "t2_left_out");
    probe(600, 50,  1'b1, "t2_left_in");
    probe(679, 50,  1'b1, "t2_right_in");
    probe(680, 50,  1'b0, "t2_right_out");
    probe(650, 600, 1'b0, "t2_vblank");

    // 4: scoring on tick 340 only.
    repeat (238) do_tick(1'b1, sp);
    do_tick(1'b1, sp);
    check("t4_tick339", 32'(sp), 32'd0);
    do_tick(1'b1, sp);
    check("t4_tick340", 32'(sp), 32'd1);
    check("t4_x0", 32'(dut.x_q[0]), 32'd120);
    do_tick(1'b1, sp);
    check("t4_tick341", 32'(sp), 32'd0);

    // 3: wrap on tick 440.
    repeat (98) do_tick(1'b1, sp);
    do_tick(1'b1, sp);
    check("t3_x0_wrap", 32'(dut.x_q[0]), 32'd820);
    check("t3_gap0_range", 32'(dut.gap_y_q[0] >= 10'd100 && dut.gap_y_q[0] <= 10'd355), 32'd1);
    check_model("t3");

    // 5: frozen for 50 frames; drawing continues. Pipe 1 is at x=220 with gap 164..323.
    repeat (50) do_tick(1'b0, sp);
    check_model("t5_frozen");
    probe(250, 10,  1'b1, "t5_draw");
    probe(250, 200, 1'b0, "t5_gap");
    do_tick(1'b1, sp);
    check("t5_resume_x1", 32'(dut.x_q[1]), 32'd218);
    check("t5_resume_x0", 32'(dut.x_q[0]), 32'd818);

    // 6: reset mid-line after 200 ticks.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (200) do_tick(1'b1, sp);
    check("t6_x0", 32'(dut.x_q[0]), 32'd400);
    probe(400, 300, 1'b1, "t6_pre");
    rst = 1'b1;
    @(negedge clk);
    check("t6_rst_valid", 32'(valid), 32'd0);
    check("t6_rst_rgb", 32'(rgb), 32'd0);
    check("t6_rst_x0", 32'(dut.x_q[0]), 32'd800);
    rst = 1'b0;
    model_reset();
    any_v      = 1'b0;
    vif.vcount = 11'd300;
    for (int h = 0; h < 800; h++) begin
      vif.hcount = 11'(h);
      @(negedge clk);
      any_v = any_v | valid;
    end
    check("t6_no_pipe_lt800", 32'(any_v), 32'd0);
    check_model("t6_after");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
